// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmu_pkg
// Description : Shared types and sizing helpers for the weight-stationary MMU.
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FILLING   = 2'd1,
        ST_FULL      = 2'd2,
        ST_SWAP_WAIT = 2'd3
    } wfsm_state_t;

    function automatic int mmu_latency(input int rows, input int cols);
        return rows + cols;
    endfunction

    // Must hold LATENCY+1: a new vector can be accepted in the same cycle
    // the oldest result is still being presented.
    function automatic int mmu_inflight_width(input int rows, input int cols);
        return $clog2(mmu_latency(rows, cols) + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws_processing_element.sv
`default_nettype none
// ============================================================================
// Module      : ws_processing_element
// Description : One MAC cell: double-buffered weight, activation passed right,
//               partial sum passed down.
// Revision    : 1.0 - initial release
// ============================================================================
module ws_processing_element #(
    parameter int DATA_WIDTH             = 8,
    parameter int ACCUMULATOR_DATA_WIDTH = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_sync_rst,
    input  logic                                     i_en,
    input  logic                                     i_weight_we,
    input  logic signed [DATA_WIDTH-1:0]             i_weight,
    input  logic                                     i_commit,
    input  logic signed [DATA_WIDTH-1:0]             i_act,
    input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] i_psum,
    output logic signed [DATA_WIDTH-1:0]             o_act,
    output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] o_psum
);

    logic signed [DATA_WIDTH-1:0]             r_weight_shadow;
    logic signed [DATA_WIDTH-1:0]             r_weight_active;
    logic signed [DATA_WIDTH-1:0]             r_act;
    logic signed [ACCUMULATOR_DATA_WIDTH-1:0] r_psum;
    logic signed [2*DATA_WIDTH-1:0]           w_product;
    logic signed [ACCUMULATOR_DATA_WIDTH-1:0] w_sum;

    // Full-precision signed product, then sign-extended; the sum wraps.
    assign w_product = (2*DATA_WIDTH)'(i_act) * (2*DATA_WIDTH)'(r_weight_active);
    assign w_sum     = i_psum + ACCUMULATOR_DATA_WIDTH'(w_product);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_weight_shadow <= '0;
            r_weight_active <= '0;
            r_act           <= '0;
            r_psum          <= '0;
        end else if (i_sync_rst) begin
            r_weight_shadow <= '0;
            r_weight_active <= '0;
            r_act           <= '0;
            r_psum          <= '0;
        end else if (i_en) begin
            if (i_weight_we) r_weight_shadow <= i_weight;
            if (i_commit)    r_weight_active <= r_weight_shadow;
            r_act  <= i_act;
            r_psum <= w_sum;
        end
    end

    assign o_act  = r_act;
    assign o_psum = r_psum;

endmodule
`default_nettype wire

// File: rtl/systolic_array_ws.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_ws
// Description : ROWS x COLS weight-stationary systolic matrix multiply with
//               double-buffered weights, input skew and output deskew.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_ws
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int ACCUMULATOR_DATA_WIDTH = 32,
    parameter int ROWS                   = 16,
    parameter int COLS                   = 16
) (
    input  logic                                   CLK,
    input  logic                                   ASYNC_RST,
    input  logic                                   SYNC_RST,
    input  logic                                   EN,
    input  logic                                   Weight_Valid,
    output logic                                   Weight_Ready,
    input  logic [COLS*DATA_WIDTH-1:0]             Weights_In,
    input  logic                                   Swap,
    input  logic                                   In_Valid,
    output logic                                   In_Ready,
    input  logic [ROWS*DATA_WIDTH-1:0]             Inputs,
    output logic                                   Out_Valid,
    output logic [COLS*ACCUMULATOR_DATA_WIDTH-1:0] Result,
    output logic                                   Busy
);

    localparam int c_dw      = DATA_WIDTH;
    localparam int c_aw      = ACCUMULATOR_DATA_WIDTH;
    localparam int c_latency = mmu_latency(ROWS, COLS);
    localparam int c_cnt_w   = mmu_inflight_width(ROWS, COLS);
    localparam int c_row_w   = (ROWS > 1) ? $clog2(ROWS) : 1;

    wfsm_state_t          r_state;
    logic [c_row_w-1:0]   r_row_cnt;
    logic                 r_weight_ready;
    logic [c_cnt_w-1:0]   r_inflight;
    logic [c_latency:0]   r_vld_pipe;

    logic                 w_accept;
    logic                 w_commit;
    logic signed [c_dw-1:0] w_act  [ROWS][COLS+1];
    logic signed [c_aw-1:0] w_psum [ROWS+1][COLS];

    assign In_Ready     = (r_state != ST_SWAP_WAIT);
    assign Weight_Ready = r_weight_ready;
    assign w_accept     = In_Valid & In_Ready & EN;
    // Active weights only change once nothing computed with them is in flight.
    assign w_commit     = EN & (r_inflight == '0) &
                          (((r_state == ST_FULL) & Swap & ~w_accept) | (r_state == ST_SWAP_WAIT));
    assign Out_Valid    = r_vld_pipe[c_latency];
    assign Busy         = (r_inflight != '0);

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            r_state        <= ST_EMPTY;
            r_row_cnt      <= '0;
            r_weight_ready <= 1'b1;
        end else if (SYNC_RST) begin
            r_state        <= ST_EMPTY;
            r_row_cnt      <= '0;
            r_weight_ready <= 1'b1;
        end else if (EN) begin
            unique case (r_state)
                ST_EMPTY, ST_FILLING: begin
                    if (Weight_Valid) begin
                        if (r_row_cnt == c_row_w'(ROWS - 1)) begin
                            r_state        <= ST_FULL;
                            r_row_cnt      <= '0;
                            r_weight_ready <= 1'b0;
                        end else begin
                            r_state   <= ST_FILLING;
                            r_row_cnt <= r_row_cnt + c_row_w'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (Swap) begin
                        if (w_commit) begin
                            r_state        <= ST_EMPTY;
                            r_weight_ready <= 1'b1;
                        end else begin
                            r_state <= ST_SWAP_WAIT;
                        end
                    end
                end
                ST_SWAP_WAIT: begin
                    if (w_commit) begin
                        r_state        <= ST_EMPTY;
                        r_weight_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            r_inflight <= '0;
            r_vld_pipe <= '0;
        end else if (SYNC_RST) begin
            r_inflight <= '0;
            r_vld_pipe <= '0;
        end else if (EN) begin
            r_vld_pipe <= {r_vld_pipe[c_latency-1:0], w_accept};
            if (w_accept & ~Out_Valid)
                r_inflight <= r_inflight + c_cnt_w'(1);
            else if (~w_accept & Out_Valid)
                r_inflight <= r_inflight - c_cnt_w'(1);
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_top_psum
        assign w_psum[0][c] = '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic signed [c_dw-1:0] r_in;
        logic                   w_row_we;

        assign w_row_we = EN & Weight_Valid & r_weight_ready & (r_row_cnt == c_row_w'(r));

        always_ff @(posedge CLK or posedge ASYNC_RST) begin
            if (ASYNC_RST)     r_in <= '0;
            else if (SYNC_RST) r_in <= '0;
            else if (w_accept) r_in <= Inputs[r*c_dw +: c_dw];
        end

        if (r == 0) begin : g_noskew
            assign w_act[r][0] = r_in;
        end else begin : g_skew
            logic signed [c_dw-1:0] r_sk [r];
            always_ff @(posedge CLK or posedge ASYNC_RST) begin
                if (ASYNC_RST) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else if (SYNC_RST) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else if (EN) begin
                    r_sk[0] <= r_in;
                    for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_act[r][0] = r_sk[r-1];
        end

        for (genvar c = 0; c < COLS; c++) begin : g_col
            ws_processing_element #(
                .DATA_WIDTH             (c_dw),
                .ACCUMULATOR_DATA_WIDTH (c_aw)
            ) u_pe (
                .clk         (CLK),
                .rst         (ASYNC_RST),
                .i_sync_rst  (SYNC_RST),
                .i_en        (EN),
                .i_weight_we (w_row_we),
                .i_weight    (Weights_In[c*c_dw +: c_dw]),
                .i_commit    (w_commit),
                .i_act       (w_act[r][c]),
                .i_psum      (w_psum[r][c]),
                .o_act       (w_act[r][c+1]),
                .o_psum      (w_psum[r+1][c])
            );
        end
    end

    // Column c leaves the array c cycles after column 0; delay the rest to align.
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int c_depth = COLS - 1 - c;
        logic signed [c_aw-1:0] w_col_out;
        logic signed [c_aw-1:0] r_res;

        if (c_depth == 0) begin : g_direct
            assign w_col_out = w_psum[ROWS][c];
        end else begin : g_delay
            logic signed [c_aw-1:0] r_dk [c_depth];
            always_ff @(posedge CLK or posedge ASYNC_RST) begin
                if (ASYNC_RST) begin
                    for (int i = 0; i < c_depth; i++) r_dk[i] <= '0;
                end else if (SYNC_RST) begin
                    for (int i = 0; i < c_depth; i++) r_dk[i] <= '0;
                end else if (EN) begin
                    r_dk[0] <= w_psum[ROWS][c];
                    for (int i = 1; i < c_depth; i++) r_dk[i] <= r_dk[i-1];
                end
            end
            assign w_col_out = r_dk[c_depth-1];
        end

        always_ff @(posedge CLK or posedge ASYNC_RST) begin
            if (ASYNC_RST)     r_res <= '0;
            else if (SYNC_RST) r_res <= '0;
            else if (EN)       r_res <= w_col_out;
        end

        assign Result[c*c_aw +: c_aw] = r_res;
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_ws
// Description : Self-checking bench for systolic_array_ws (4x4, 16-bit acc).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_ws;

    localparam int DW   = 8;
    localparam int ACCW = 16;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int LAT  = ROWS + COLS;

    logic                 CLK = 1'b0;
    logic                 ASYNC_RST, SYNC_RST, EN;
    logic                 Weight_Valid, Weight_Ready, Swap;
    logic                 In_Valid, In_Ready, Out_Valid, Busy;
    logic [COLS*DW-1:0]   Weights_In;
    logic [ROWS*DW-1:0]   Inputs;
    logic [COLS*ACCW-1:0] Result;

    always #5 CLK = ~CLK;

    systolic_array_ws #(
        .DATA_WIDTH             (DW),
        .ACCUMULATOR_DATA_WIDTH (ACCW),
        .ROWS                   (ROWS),
        .COLS                   (COLS)
    ) dut (
        .CLK          (CLK),
        .ASYNC_RST    (ASYNC_RST),
        .SYNC_RST     (SYNC_RST),
        .EN           (EN),
        .Weight_Valid (Weight_Valid),
        .Weight_Ready (Weight_Ready),
        .Weights_In   (Weights_In),
        .Swap         (Swap),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .Inputs       (Inputs),
        .Out_Valid    (Out_Valid),
        .Result       (Result),
        .Busy         (Busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference: shadow/active matrices, rows loaded, pending swap, and a
    // queue of accepted vectors with enabled cycles left until they appear.
    int  m_shadow [ROWS][COLS];
    int  m_active [ROWS][COLS];
    int  m_rows;
    bit  m_pending;
    typedef struct { logic [63:0] res; int remaining; } exp_t;
    exp_t q[$];

    int vec  [ROWS];
    int wrow [COLS];
    int wtmp [ROWS][COLS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_shadow[r, c]) begin
            m_shadow[r][c] = 0;
            m_active[r][c] = 0;
        end
        m_rows    = 0;
        m_pending = 1'b0;
        q.delete();
    endtask

    task automatic commit();
        m_active  = m_shadow;
        m_rows    = 0;
        m_pending = 1'b0;
    endtask

    function automatic logic [63:0] model_result();
        logic [63:0] res = '0;
        for (int c = 0; c < COLS; c++) begin
            int s = 0;
            for (int r = 0; r < ROWS; r++) s += vec[r] * m_active[r][c];
            res[c*ACCW +: ACCW] = ACCW'(s);
        end
        return res;
    endfunction

    task automatic drive_vec();
        for (int r = 0; r < ROWS; r++) Inputs[r*DW +: DW] = DW'(vec[r]);
    endtask

    task automatic drive_wrow();
        for (int c = 0; c < COLS; c++) Weights_In[c*DW +: DW] = DW'(wrow[c]);
    endtask

    task automatic rand_vec();
        for (int r = 0; r < ROWS; r++) vec[r] = int'($urandom_range(0, 255)) - 128;
        drive_vec();
    endtask

    // One clock: update the reference for this edge, then check all outputs.
    task automatic tick();
        bit          acc, beat, exp_v;
        logic [63:0] res;
        acc  = In_Valid && EN && !m_pending && !SYNC_RST;
        beat = Weight_Valid && EN && (m_rows < ROWS) && !SYNC_RST;
        res  = model_result();
        if (EN && !SYNC_RST) begin
            if (beat) begin
                for (int c = 0; c < COLS; c++) m_shadow[m_rows][c] = wrow[c];
                m_rows++;
            end else if (m_pending) begin
                if (q.size() == 0) commit();
            end else if (Swap && m_rows == ROWS) begin
                if (q.size() == 0 && !acc) commit();
                else m_pending = 1'b1;
            end
            if (q.size() > 0 && q[0].remaining == 0) void'(q.pop_front());
            foreach (q[i]) q[i].remaining--;
            if (acc) q.push_back('{res, LAT});
        end
        @(posedge CLK);
        if (SYNC_RST) model_reset();
        #1;
        exp_v = (q.size() > 0) && (q[0].remaining == 0);
        chk("out_valid", Out_Valid, exp_v);
        if (exp_v) chk("result", Result, q[0].res);
        chk("busy", Busy, q.size() != 0);
        chk("in_ready", In_Ready, !m_pending);
        chk("weight_ready", Weight_Ready, m_rows < ROWS);
    endtask

    task automatic load_weights();
        Weight_Valid = 1'b1;
        for (int k = 0; k < ROWS; k++) begin
            for (int c = 0; c < COLS; c++) wrow[c] = wtmp[k][c];
            drive_wrow();
            tick();
        end
        Weight_Valid = 1'b0;
    endtask

    task automatic do_swap();
        Swap = 1'b1;
        tick();
        Swap = 1'b0;
    endtask

    task automatic drain();
        In_Valid = 1'b0;
        repeat (LAT + 3) tick();
    endtask

    task automatic async_reset_pulse();
        #2 ASYNC_RST = 1'b1;
        #1;
        model_reset();
        chk("arst_out_valid", Out_Valid, 0);
        chk("arst_result", Result, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_in_ready", In_Ready, 1);
        chk("arst_weight_ready", Weight_Ready, 1);
        In_Valid = 1'b0; Weight_Valid = 1'b0; Swap = 1'b0;
        @(posedge CLK);
        #1 ASYNC_RST = 1'b0;
    endtask

    initial begin
        ASYNC_RST = 1'b1; SYNC_RST = 1'b0; EN = 1'b1;
        Weight_Valid = 1'b0; Swap = 1'b0; In_Valid = 1'b0;
        Weights_In = '0; Inputs = '0;
        model_reset();
        @(posedge CLK); #1;
        chk("reset_out_valid", Out_Valid, 0);
        chk("reset_result", Result, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_in_ready", In_Ready, 1);
        chk("reset_weight_ready", Weight_Ready, 1);
        @(posedge CLK); #1 ASYNC_RST = 1'b0;

        // Identity weights: result equals the input, exactly LAT cycles later.
        foreach (wtmp[r, c]) wtmp[r][c] = (r == c) ? 1 : 0;
        load_weights();
        do_swap();
        vec[0] = 1; vec[1] = -2; vec[2] = 3; vec[3] = -4;
        drive_vec();
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        repeat (LAT - 1) tick();
        chk("identity_early", Out_Valid, 0);
        tick();
        chk("identity_valid", Out_Valid, 1);
        chk("identity_result", Result, 64'hFFFC_0003_FFFE_0001);
        drain();

        // -128 everywhere: 4 * 16384 = 65536 wraps to 0 in 16 bits.
        foreach (wtmp[r, c]) wtmp[r][c] = -128;
        load_weights();
        do_swap();
        foreach (vec[r]) vec[r] = -128;
        drive_vec();
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        repeat (LAT) tick();
        chk("wrap_result", Result, 64'h0);
        drain();

        // Random weights, 20 back-to-back vectors.
        foreach (wtmp[r, c]) wtmp[r][c] = int'($urandom_range(0, 255)) - 128;
        load_weights();
        do_swap();
        In_Valid = 1'b1;
        repeat (20) begin rand_vec(); tick(); end
        drain();

        // New shadow weights loaded while streaming, then Swap while busy.
        foreach (wtmp[r, c]) wtmp[r][c] = int'($urandom_range(0, 255)) - 128;
        In_Valid = 1'b1;
        Weight_Valid = 1'b1;
        for (int k = 0; k < ROWS; k++) begin
            for (int c = 0; c < COLS; c++) wrow[c] = wtmp[k][c];
            drive_wrow();
            rand_vec();
            tick();
        end
        Weight_Valid = 1'b0;
        rand_vec();
        do_swap();
        chk("swap_wait_in_ready", In_Ready, 0);
        repeat (LAT + 10) begin rand_vec(); tick(); end
        drain();

        // EN low for 3 cycles mid-stream.
        In_Valid = 1'b1;
        repeat (3) begin rand_vec(); tick(); end
        EN = 1'b0;
        repeat (3) begin rand_vec(); tick(); end
        EN = 1'b1;
        repeat (2) begin rand_vec(); tick(); end
        drain();

        // Asynchronous reset mid-stream and mid-weight-load.
        In_Valid = 1'b1;
        Weight_Valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < COLS; c++) wrow[c] = int'($urandom_range(1, 100));
            drive_wrow();
            rand_vec();
            tick();
        end
        async_reset_pulse();
        rand_vec();
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        repeat (LAT) tick();
        chk("post_reset_zero_result", Result, 64'h0);
        drain();

        // Synchronous clear wins over EN low and discards in-flight vectors.
        foreach (wtmp[r, c]) wtmp[r][c] = int'($urandom_range(0, 255)) - 128;
        load_weights();
        do_swap();
        In_Valid = 1'b1;
        repeat (3) begin rand_vec(); tick(); end
        In_Valid = 1'b0;
        EN = 1'b0;
        SYNC_RST = 1'b1;
        tick();
        SYNC_RST = 1'b0;
        EN = 1'b1;
        chk("srst_busy", Busy, 0);
        chk("srst_result", Result, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
